// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage feeding the decode controller. Owns the PC, issues
//   in-order requests to a variable-latency instruction memory, buffers the
//   returned words and hands them to decode with pre-sliced opcode fields.
//   Redirects restart fetch at a new PC and discard every in-flight fetch.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   imem_req_valid/ready/addr     fetch request channel (addr = pc)
//   imem_resp_valid/data          in-order responses, latency >= 1
//   redirect_valid/pc             single-cycle taken branch/jump
//   dec_valid/ready               head-of-buffer handshake to decode
//   dec_instr, dec_pc, dec_pc_plus4, dec_op, dec_func3, dec_func7
//                                 head entry and its decoded fields (0 when empty)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_plus4,
  output logic [6:0]      dec_op,
  output logic [2:0]      dec_func3,
  output logic [6:0]      dec_func7
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // PC tags of outstanding requests, popped in step with responses
  logic [XLEN-1:0] tag_mem [DEPTH];
  logic [PW-1:0]   tag_wr_q, tag_wr_d;
  logic [PW-1:0]   tag_rd_q, tag_rd_d;

  // Instruction buffer
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [31:0]     buf_instr [DEPTH];
  logic [PW-1:0]   buf_wr_q, buf_wr_d;
  logic [PW-1:0]   buf_rd_q, buf_rd_d;

  logic            issue;
  logic            resp_acc;
  logic            resp_keep;
  logic            pop;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic            unused_redirect_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign credit_used    = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign issue          = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding belongs to a pre-reset request.
  assign resp_acc  = imem_resp_valid && (out_q != '0);
  assign resp_keep = resp_acc && (drop_q == '0) && !redirect_valid;

  assign dec_valid = (cnt_q != '0);
  assign pop       = dec_valid && dec_ready;

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    buf_wr_d = buf_wr_q;
    buf_rd_d = buf_rd_q;

    if (issue) begin
      tag_wr_d = ptr_inc(tag_wr_q);
    end
    if (resp_acc) begin
      tag_rd_d = ptr_inc(tag_rd_q);
    end

    if (issue && !resp_acc) begin
      out_d = out_q + CW'(1);
    end else if (!issue && resp_acc) begin
      out_d = out_q - CW'(1);
    end

    if (redirect_valid) begin
      pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      // Everything still pending after this cycle is wrong-path.
      drop_d   = resp_acc ? (out_q - CW'(1)) : out_q;
      cnt_d    = '0;
      buf_wr_d = '0;
      buf_rd_d = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (resp_acc && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (resp_keep) begin
        buf_wr_d = ptr_inc(buf_wr_q);
      end
      if (pop) begin
        buf_rd_d = ptr_inc(buf_rd_q);
      end
      if (resp_keep && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!resp_keep && pop) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      buf_wr_q <= '0;
      buf_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      buf_wr_q <= buf_wr_d;
      buf_rd_q <= buf_rd_d;
    end
  end

  // Storage arrays need no reset; pointers and counts qualify their contents.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (resp_keep) begin
      buf_pc[buf_wr_q]    <= tag_mem[tag_rd_q];
      buf_instr[buf_wr_q] <= imem_resp_data;
    end
  end

  assign head_pc    = dec_valid ? buf_pc[buf_rd_q]    : '0;
  assign head_instr = dec_valid ? buf_instr[buf_rd_q] : '0;

  assign dec_instr    = head_instr;
  assign dec_pc       = head_pc;
  assign dec_pc_plus4 = dec_valid ? (head_pc + XLEN'(4)) : '0;
  assign dec_op       = head_instr[6:0];
  assign dec_func3    = head_instr[14:12];
  assign dec_func7    = head_instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage with a fixed-latency in-order memory model.
//   Expected values are hand-derived cycle by cycle from the fetch behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic [6:0]  dec_op;
  logic [2:0]  dec_func3;
  logic [6:0]  dec_func7;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_plus4   (dec_pc_plus4),
    .dec_op         (dec_op),
    .dec_func3      (dec_func3),
    .dec_func7      (dec_func7)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t memq[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    lat      = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a == 32'h0) ? 32'h40B5_0533 : ((a << 8) | 32'h13);
  endfunction

  // One clock: record what the DUT does at this edge, then drive the memory
  // response due in the new cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    // outstanding + buffered never exceeds two, so a new request can only
    // be accepted with at most one response still owed by memory
    if (acc) check("credit_invariant", 64'(memq.size() < 2), 64'd1);
    if (imem_resp_valid) void'(memq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
    if (acc) memq.push_back('{cyc - 1 + lat, instr_of(a)});
    if (memq.size() > 0 && memq[0].due == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memq[0].data;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic do_reset(input int l);
    rst            = 1'b1;
    lat            = l;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_dec(input string tag);
    int n = 0;
    while (!dec_valid && n < 12) begin
      tick();
      n++;
    end
    check(tag, 64'(dec_valid), 64'd1);
  endtask

  initial begin
    logic seen;
    int   n;

    // reset values
    repeat (3) tick();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_pc", 64'(dec_pc), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_dec_pc_plus4", 64'(dec_pc_plus4), 64'd0);

    // latency 1 streaming, field slicing
    do_reset(1);
    check("t1_req_valid", 64'(imem_req_valid), 64'd1);
    check("t1_addr0", 64'(imem_req_addr), 64'h0);
    tick();
    check("t1_no_bypass", 64'(dec_valid), 64'd0);
    check("t1_addr1", 64'(imem_req_addr), 64'h4);
    tick();
    check("t1_valid0", 64'(dec_valid), 64'd1);
    check("t1_pc0", 64'(dec_pc), 64'h0);
    check("t1_instr0", 64'(dec_instr), 64'h40B5_0533);
    check("t1_op", 64'(dec_op), 64'h33);
    check("t1_func3", 64'(dec_func3), 64'h0);
    check("t1_func7", 64'(dec_func7), 64'h20);
    check("t1_plus4_0", 64'(dec_pc_plus4), 64'h4);
    tick();
    check("t1_pc1", 64'(dec_pc), 64'h4);
    check("t1_instr1", 64'(dec_instr), 64'h413);
    check("t1_plus4_1", 64'(dec_pc_plus4), 64'h8);
    check("t1_addr2", 64'(imem_req_addr), 64'h8);
    tick();
    check("t1_gap", 64'(dec_valid), 64'd0);
    check("t1_addr3", 64'(imem_req_addr), 64'hC);
    tick();
    check("t1_pc2", 64'(dec_pc), 64'h8);
    check("t1_instr2", 64'(dec_instr), 64'h813);
    check("t1_plus4_2", 64'(dec_pc_plus4), 64'hC);

    // decode backpressure fills the buffer and stops fetch
    do_reset(1);
    dec_ready = 1'b0;
    repeat (3) tick();
    check("t3_full_req", 64'(imem_req_valid), 64'd0);
    check("t3_hold_valid", 64'(dec_valid), 64'd1);
    check("t3_hold_pc_a", 64'(dec_pc), 64'h0);
    tick();
    check("t3_full_req_b", 64'(imem_req_valid), 64'd0);
    check("t3_hold_pc_b", 64'(dec_pc), 64'h0);
    check("t3_hold_instr", 64'(dec_instr), 64'h40B5_0533);
    dec_ready = 1'b1;
    tick();
    check("t3_resume_req", 64'(imem_req_valid), 64'd1);
    check("t3_resume_addr", 64'(imem_req_addr), 64'h8);
    check("t3_next_pc", 64'(dec_pc), 64'h4);

    // latency 3, redirect with two requests in flight
    do_reset(3);
    tick();
    tick();
    check("t4_credit_block", 64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    #1;
    seen = 1'b0;
    n    = 0;
    while (!imem_req_valid && n < 10) begin
      seen |= dec_valid;
      tick();
      n++;
    end
    check("t4_req_after_redirect", 64'(imem_req_valid), 64'd1);
    check("t4_redirect_addr", 64'(imem_req_addr), 64'h100);
    check("t4_no_wrongpath", 64'(seen), 64'd0);
    wait_dec("t4_dec_timeout");
    check("t4_dec_pc", 64'(dec_pc), 64'h100);
    check("t4_dec_instr", 64'(dec_instr), 64'(instr_of(32'h100)));

    // redirect together with a response and a decode pop
    do_reset(1);
    tick();
    tick();
    check("t5_pre_valid", 64'(dec_valid), 64'd1);
    check("t5_pre_pc", 64'(dec_pc), 64'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h201;
    #1;
    check("t5_no_req_redirect", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5_flushed", 64'(dec_valid), 64'd0);
    check("t5_req_valid", 64'(imem_req_valid), 64'd1);
    check("t5_addr", 64'(imem_req_addr), 64'h200);
    tick();
    tick();
    check("t5_dec_valid", 64'(dec_valid), 64'd1);
    check("t5_dec_pc", 64'(dec_pc), 64'h200);
    check("t5_dec_instr", 64'(dec_instr), 64'(instr_of(32'h200)));

    // redirect with idle credits still issues nothing that cycle
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h301;
    #1;
    check("t5b_no_req_redirect", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5b_req_valid", 64'(imem_req_valid), 64'd1);
    check("t5b_addr", 64'(imem_req_addr), 64'h300);

    // reset with two outstanding; stale responses must be ignored
    do_reset(3);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("t6_rst_dec_valid", 64'(dec_valid), 64'd0);
    tick();
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    check("t6_stall_addr_a", 64'(imem_req_addr), 64'h0);
    check("t6_stall_valid", 64'(imem_req_valid), 64'd1);
    check("t6_stale_a", 64'(dec_valid), 64'd0);
    tick();
    check("t6_stall_addr_b", 64'(imem_req_addr), 64'h0);
    check("t6_stale_b", 64'(dec_valid), 64'd0);
    imem_req_ready = 1'b1;
    tick();
    check("t6_addr_after", 64'(imem_req_addr), 64'h4);
    check("t6_stale_c", 64'(dec_valid), 64'd0);
    wait_dec("t6_dec_timeout");
    check("t6_dec_pc", 64'(dec_pc), 64'h0);
    check("t6_dec_instr", 64'(dec_instr), 64'h40B5_0533);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
